// File: rtl/gem_trig_link_formatter.sv
// Multi-link GEM trigger-fiber formatter: K-char framed S-bit payloads with sync FSM and PRBS-31 test source.
// Optional: define GEM_TRIG_LINK_BC0_MARKER_EN to mark BC0 frames with a K28.2 separator.

module gem_trig_link_lane #(
  parameter int FRAME_WORDS = 2,
  parameter int DW          = 32*FRAME_WORDS-8,
  parameter int WCW         = 1
) (
  input  logic           TRG_CLK80,
  input  logic           TRG_RST,
  input  logic           run,
  input  logic           cap_en,
  input  logic           last_w,
  input  logic [WCW-1:0] wcnt,
  input  logic [DW-1:0]  pay,
  input  logic           ovf,
  input  logic           bc0_mark,
  input  logic [7:0]     seq_sep,
  output logic [31:0]    tx_data,
  output logic [3:0]     tx_isk
);
  // Word 0 goes out live, so only the remaining DW-32 payload bits need holding.
  logic [DW-33:0]                hold;
  logic [7:0]                    sep;
  logic [FRAME_WORDS-1:0][31:0]  words;

  always_comb begin
    sep = bc0_mark ? 8'h5C : (ovf ? 8'hFC : seq_sep);
    words = '0;
    words[0] = pay[DW-1 -: 32];
    for (int k = 1; k < FRAME_WORDS-1; k++)
      words[k] = hold[DW-33-32*(k-1) -: 32];
    words[FRAME_WORDS-1] = {hold[23:0], sep};
  end

  always_ff @(posedge TRG_CLK80) begin
    if (TRG_RST) begin
      hold    <= '0;
      tx_data <= 32'h50BC50BC;
      tx_isk  <= 4'b0101;
    end else begin
      if (cap_en) hold <= pay[DW-33:0];
      if (run) begin
        tx_data <= words[wcnt];
        tx_isk  <= last_w ? 4'b0001 : 4'b0000;
      end else begin
        tx_data <= 32'h50BC50BC;
        tx_isk  <= 4'b0101;
      end
    end
  end
endmodule

module gem_trig_link_formatter #(
  parameter int NLINKS         = 2,
  parameter int FRAME_WORDS    = 2,
  parameter int FRAME_CTRL_TTC = 0,
  parameter int SYNC_FRAMES    = 4,
  parameter int LTNCY_BITS     = 8
) (
  input  logic                              TRG_CLK80,
  input  logic                              TRG_RST,
  input  logic [NLINKS*(32*FRAME_WORDS-8)-1:0] GEM_DATA,
  input  logic [NLINKS-1:0]                 GEM_OVERFLOW,
  input  logic [11:0]                       BXN_COUNTER,
  input  logic                              BC0,
  input  logic                              ENA_TEST_PAT,
  input  logic                              PRBS_RST,
  input  logic                              INJ_ERR,
  output logic [NLINKS*32-1:0]              TRG_TX_DATA,
  output logic [NLINKS*4-1:0]               TRG_TX_ISK,
  output logic                              FRAME_START,
  output logic                              TX_SYNC_DONE,
  output logic                              LTNCY_TRIG
);
  localparam int DW  = 32*FRAME_WORDS-8;
  localparam int WCW = $clog2(FRAME_WORDS);
  localparam int SCW = $clog2(SYNC_FRAMES)+1;
  localparam logic [30:0] SEED = 31'h7FFFFFFF;

  typedef enum logic [1:0] {ST_RESET, ST_SYNC, ST_RUN} state_t;
  state_t state, state_nxt;

  logic [WCW-1:0]        wcnt;
  logic [SCW-1:0]        sync_cnt;
  logic [1:0]            fcnt;
  logic                  last_w, cap_en, bc0_mark;
  logic [30:0]           lfsr;
  logic [DW-1:0]         prbs_word;
  logic [7:0]            prbs_sr;
  logic                  prbs_hold;
  logic                  inj_q, armed, inj_flip;
  logic [LTNCY_BITS-1:0] lcnt;
  logic [1:0]            seq_code;
  logic [7:0]            seq_sep;
  logic                  unused_in;
  logic [NLINKS-1:0][DW-1:0] pay;
  logic [NLINKS-1:0][31:0]   tx_data;
  logic [NLINKS-1:0][3:0]    tx_isk;

  assign last_w    = (wcnt == WCW'(FRAME_WORDS-1));
  assign cap_en    = (state != ST_RESET) && (wcnt == '0);
  assign inj_flip  = cap_en && armed;
  assign prbs_hold = PRBS_RST || (|prbs_sr);
  assign unused_in = ^{BXN_COUNTER, BC0};

  always_ff @(posedge TRG_CLK80) begin
    if (TRG_RST) state <= ST_RESET;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET: state_nxt = ST_SYNC;
      ST_SYNC:  if (last_w && sync_cnt == SCW'(SYNC_FRAMES-1)) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge TRG_CLK80) begin
    if (TRG_RST || state == ST_RESET) begin
      wcnt     <= '0;
      sync_cnt <= '0;
      fcnt     <= '0;
    end else begin
      wcnt <= last_w ? '0 : WCW'(wcnt + 1'b1);
      if (last_w) begin
        fcnt <= bc0_mark ? 2'd0 : fcnt + 2'd1;
        if (state == ST_SYNC) sync_cnt <= sync_cnt + 1'b1;
      end
    end
  end

`ifdef GEM_TRIG_LINK_BC0_MARKER_EN
  logic bc0_f;
  always_ff @(posedge TRG_CLK80) begin
    if (TRG_RST || state == ST_RESET) bc0_f <= 1'b0;
    else if (cap_en)                  bc0_f <= BC0;
  end
  assign bc0_mark = bc0_f;
`else
  assign bc0_mark = 1'b0;
`endif

  // Next DW bits of the Fibonacci PRBS-31; the first generated bit lands in the MSB.
  always_comb begin
    logic [30:0] s;
    logic        b;
    s = lfsr;
    b = 1'b0;
    prbs_word = '0;
    for (int i = DW-1; i >= 0; i--) begin
      b = s[30] ^ s[27];
      prbs_word[i] = b;
      s = {s[29:0], b};
    end
  end

  // DW >= 31, so the last 31 generated bits are exactly the advanced LFSR state.
  always_ff @(posedge TRG_CLK80) begin
    if (TRG_RST) begin
      lfsr    <= SEED;
      prbs_sr <= '1;
    end else begin
      if (PRBS_RST)    prbs_sr <= '1;
      else if (cap_en) prbs_sr <= {prbs_sr[6:0], 1'b0};
      if (PRBS_RST)    lfsr <= SEED;
      else if (cap_en) lfsr <= prbs_hold ? SEED : prbs_word[30:0];
    end
  end

  always_ff @(posedge TRG_CLK80) begin
    if (TRG_RST) begin
      inj_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      inj_q <= INJ_ERR;
      if (inj_flip)                armed <= 1'b0;
      else if (INJ_ERR && !inj_q)  armed <= 1'b1;
    end
  end

  always_comb begin
    seq_code = (FRAME_CTRL_TTC != 0) ? BXN_COUNTER[1:0] : fcnt;
    case (seq_code)
      2'd0:    seq_sep = 8'hBC;
      2'd1:    seq_sep = 8'hF7;
      2'd2:    seq_sep = 8'hFB;
      default: seq_sep = 8'hFD;
    endcase
  end

  for (genvar n = 0; n < NLINKS; n++) begin : g_lane
    assign pay[n] = (ENA_TEST_PAT ? prbs_word : GEM_DATA[n*DW +: DW])
                  ^ {{(DW-1){1'b0}}, (n == 0) && inj_flip};

    gem_trig_link_lane #(.FRAME_WORDS(FRAME_WORDS), .DW(DW), .WCW(WCW)) u_lane (
      .TRG_CLK80 (TRG_CLK80),
      .TRG_RST   (TRG_RST),
      .run       (state == ST_RUN),
      .cap_en    (cap_en),
      .last_w    (last_w),
      .wcnt      (wcnt),
      .pay       (pay[n]),
      .ovf       (GEM_OVERFLOW[n]),
      .bc0_mark  (bc0_mark),
      .seq_sep   (seq_sep),
      .tx_data   (tx_data[n]),
      .tx_isk    (tx_isk[n])
    );
  end

  assign TRG_TX_DATA = tx_data;
  assign TRG_TX_ISK  = tx_isk;

  always_ff @(posedge TRG_CLK80) begin
    if (TRG_RST) begin
      FRAME_START  <= 1'b0;
      TX_SYNC_DONE <= 1'b0;
      LTNCY_TRIG   <= 1'b0;
      lcnt         <= '0;
    end else begin
      FRAME_START  <= cap_en;
      TX_SYNC_DONE <= (state == ST_RUN);
      LTNCY_TRIG   <= (state != ST_RESET) && (lcnt == '0);
      lcnt         <= (state == ST_RESET) ? '0 : lcnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_gem_trig_link_formatter.sv
// Directed bench for gem_trig_link_formatter (NLINKS=2, FRAME_WORDS=2), plus a TTC-separator instance.
module tb_gem_trig_link_formatter;
  logic          TRG_CLK80;
  logic          TRG_RST;
  logic [111:0]  GEM_DATA;
  logic [1:0]    GEM_OVERFLOW;
  logic [11:0]   BXN_COUNTER;
  logic          BC0, ENA_TEST_PAT, PRBS_RST, INJ_ERR;
  logic [63:0]   TRG_TX_DATA, t_data;
  logic [7:0]    TRG_TX_ISK, t_isk;
  logic          FRAME_START, TX_SYNC_DONE, LTNCY_TRIG;
  logic          t_fs, t_sd, t_lt;

  gem_trig_link_formatter #(.NLINKS(2), .FRAME_WORDS(2), .FRAME_CTRL_TTC(0), .SYNC_FRAMES(4), .LTNCY_BITS(8)) dut (
    .TRG_CLK80(TRG_CLK80), .TRG_RST(TRG_RST), .GEM_DATA(GEM_DATA), .GEM_OVERFLOW(GEM_OVERFLOW),
    .BXN_COUNTER(BXN_COUNTER), .BC0(BC0), .ENA_TEST_PAT(ENA_TEST_PAT), .PRBS_RST(PRBS_RST),
    .INJ_ERR(INJ_ERR), .TRG_TX_DATA(TRG_TX_DATA), .TRG_TX_ISK(TRG_TX_ISK),
    .FRAME_START(FRAME_START), .TX_SYNC_DONE(TX_SYNC_DONE), .LTNCY_TRIG(LTNCY_TRIG));

  gem_trig_link_formatter #(.NLINKS(2), .FRAME_WORDS(2), .FRAME_CTRL_TTC(1), .SYNC_FRAMES(4), .LTNCY_BITS(8)) dut_ttc (
    .TRG_CLK80(TRG_CLK80), .TRG_RST(TRG_RST), .GEM_DATA(GEM_DATA), .GEM_OVERFLOW(GEM_OVERFLOW),
    .BXN_COUNTER(BXN_COUNTER), .BC0(BC0), .ENA_TEST_PAT(ENA_TEST_PAT), .PRBS_RST(PRBS_RST),
    .INJ_ERR(INJ_ERR), .TRG_TX_DATA(t_data), .TRG_TX_ISK(t_isk),
    .FRAME_START(t_fs), .TX_SYNC_DONE(t_sd), .LTNCY_TRIG(t_lt));

  initial TRG_CLK80 = 1'b0;
  always #5 TRG_CLK80 = ~TRG_CLK80;

  int n_chk = 0, n_pass = 0, ecnt = 0;
  logic [31:0] w0 [2], w1 [2];
  logic [3:0]  i0 [2], i1 [2];
  logic        fs0, fs1, sd0;
  logic [31:0] tw1;
  logic        ref_bits [0:511];
  logic [55:0] pl0 [1:14], pl1 [1:14];
  logic [7:0]  exp0 [4], exp1 [4];
  int          err0, err1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge TRG_CLK80);
    #1;
    ecnt++;
  endtask

  task automatic do_frame(input bit mid_inj);
    step();
    fs0 = FRAME_START;
    sd0 = TX_SYNC_DONE;
    for (int n = 0; n < 2; n++) begin
      w0[n] = TRG_TX_DATA[n*32 +: 32];
      i0[n] = TRG_TX_ISK[n*4 +: 4];
    end
    if (mid_inj) INJ_ERR = 1'b1;
    step();
    fs1 = FRAME_START;
    for (int n = 0; n < 2; n++) begin
      w1[n] = TRG_TX_DATA[n*32 +: 32];
      i1[n] = TRG_TX_ISK[n*4 +: 4];
    end
    tw1 = t_data[31:0];
  endtask

  // k-th 56-bit chunk of the PRBS-31 stream; first stream bit is the MSB.
  function automatic logic [55:0] chunk(input int k);
    logic [55:0] r;
    for (int b = 0; b < 56; b++) r[55-b] = ref_bits[31 + 56*k + b];
    return r;
  endfunction

  initial begin
    // x[n] = x[n-31] ^ x[n-28] with the 31 seed bits all ones
    for (int i = 0; i < 31; i++) ref_bits[i] = 1'b1;
    for (int i = 31; i < 512; i++) ref_bits[i] = ref_bits[i-31] ^ ref_bits[i-28];
    exp0[0] = 8'hF7; exp0[1] = 8'hFB; exp0[2] = 8'hFD; exp0[3] = 8'hBC;
    exp1[0] = 8'hF7; exp1[1] = 8'hFC; exp1[2] = 8'hFD; exp1[3] = 8'hBC;

    TRG_RST = 1'b1; GEM_DATA = '0; GEM_OVERFLOW = '0; BXN_COUNTER = '0;
    BC0 = 1'b0; ENA_TEST_PAT = 1'b0; PRBS_RST = 1'b0; INJ_ERR = 1'b0;
    repeat (3) step();
    chk("rst_data", TRG_TX_DATA, 64'h50BC50BC_50BC50BC);
    chk("rst_isk", TRG_TX_ISK, 8'b0101_0101);
    chk("rst_fs", FRAME_START, 1'b0);
    chk("rst_sd", TX_SYNC_DONE, 1'b0);
    chk("rst_lt", LTNCY_TRIG, 1'b0);

    BXN_COUNTER = 12'h002;
    GEM_DATA = {56'h11223344556677, 56'h0123456789ABCD};
    TRG_RST = 1'b0;
    step();
    ecnt = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("sync_data", TRG_TX_DATA, 64'h50BC50BC_50BC50BC);
      chk("sync_isk", TRG_TX_ISK, 8'b0101_0101);
      chk("sync_sd", TX_SYNC_DONE, 1'b0);
      if (i == 1) chk("lt_first", LTNCY_TRIG, 1'b1);
      if (i == 2) chk("lt_second", LTNCY_TRIG, 1'b0);
    end

    do_frame(1'b0);
    chk("run_sd", sd0, 1'b1);
    chk("run_fs0", fs0, 1'b1);
    chk("run_fs1", fs1, 1'b0);
    chk("f0_w0", w0[0], 32'h01234567);
    chk("f0_i0", i0[0], 4'b0000);
    chk("f0_w1", w1[0], 32'h89ABCDBC);
    chk("f0_i1", i1[0], 4'b0001);
    chk("f0_l1w1", w1[1], 32'h556677BC);
    chk("ttc_sep", tw1, 32'h89ABCDFB);

    for (int j = 0; j < 4; j++) begin
      GEM_OVERFLOW = (j == 1) ? 2'b10 : 2'b00;
      do_frame(1'b0);
      chk("seq_l0", w1[0], {24'h89ABCD, exp0[j]});
      chk("seq_l1", w1[1], {24'h556677, exp1[j]});
    end
    GEM_OVERFLOW = '0;

    BC0 = 1'b1;
    do_frame(1'b0);
    BC0 = 1'b0;
`ifdef GEM_TRIG_LINK_BC0_MARKER_EN
    chk("bc0_l0", w1[0][7:0], 8'h5C);
    chk("bc0_l1", w1[1][7:0], 8'h5C);
    do_frame(1'b0);
    chk("bc0_next", w1[0][7:0], 8'hBC);
`else
    chk("bc0_l0", w1[0][7:0], 8'hF7);
    chk("bc0_l1", w1[1][7:0], 8'hF7);
    do_frame(1'b0);
    chk("bc0_next", w1[0][7:0], 8'hFB);
`endif

    // PRBS_RST pulse lands on a last-word edge so it never coincides with a capture
    ENA_TEST_PAT = 1'b1;
    step();
    PRBS_RST = 1'b1;
    step();
    PRBS_RST = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      do_frame(k == 10);
      pl0[k] = {w0[0], w1[0][31:8]};
      pl1[k] = {w0[1], w1[1][31:8]};
    end
    INJ_ERR = 1'b0;
    err0 = 0; err1 = 0;
    for (int k = 1; k <= 14; k++) begin
      if (pl0[k] !== chunk(k <= 9 ? 0 : k-9)) err0++;
      if (pl1[k] !== chunk(k <= 9 ? 0 : k-9)) err1++;
    end
    chk("prbs_b1", pl0[1], chunk(0));
    chk("prbs_b9", pl0[9], chunk(0));
    chk("prbs_b10", pl0[10], chunk(1));
    chk("prbs_b12", pl0[12], chunk(3));
    chk("prbs_inj_bit", pl0[11] ^ chunk(2), 56'h1);
    chk("prbs_err_l0", err0, 1);
    chk("prbs_err_l1", err1, 0);
    chk("prbs_isk", i1[0], 4'b0001);

    while (ecnt < 256) step();
    chk("lt_gap", LTNCY_TRIG, 1'b0);
    step();
    chk("lt_period", LTNCY_TRIG, 1'b1);
    chk("pre_rst_fs", FRAME_START, 1'b1);

    TRG_RST = 1'b1;
    ENA_TEST_PAT = 1'b0;
    step();
    chk("mid_rst_data", TRG_TX_DATA, 64'h50BC50BC_50BC50BC);
    chk("mid_rst_sd", TX_SYNC_DONE, 1'b0);
    TRG_RST = 1'b0;
    step();
    chk("resync_data0", TRG_TX_DATA, 64'h50BC50BC_50BC50BC);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("resync_data", TRG_TX_DATA, 64'h50BC50BC_50BC50BC);
      chk("resync_sd", TX_SYNC_DONE, 1'b0);
    end
    do_frame(1'b0);
    chk("rerun_sd", sd0, 1'b1);
    chk("rerun_w0", w0[0], 32'h01234567);
    chk("rerun_w1", w1[0], 32'h89ABCDBC);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/gem_trig_link_formatter.md
Name: gem_trig_link_formatter

Overview:
- Multi-link, parametrised successor to the GEM trigger-fiber frame builder.
- Per bunch crossing, serialises one S-bit cluster payload per link into FRAME_WORDS 32-bit words, with 8b10b K-character framing, ready for the GTX/GTP TXDATA/TXCHARISK ports.
- Adds:
  - an explicit reset/sync state machine;
  - a per-link payload holding register;
  - a built-in PRBS-31 test-pattern generator with delayed reset release and single-shot error injection;
  - selectable local or TTC-locked frame separators.

Parameters:
- NLINKS, 2, number of trigger links formatted in parallel.
- FRAME_WORDS, 2, 32-bit words per frame (2..4); payload width DW = 32*FRAME_WORDS-8.
- FRAME_CTRL_TTC, 0, 0 = separator from local frame counter; 1 = from BXN_COUNTER[1:0].
- SYNC_FRAMES, 4, comma-only frames sent after reset release before data.
- LTNCY_BITS, 8, width of the latency-trigger clock counter.

Ports:
- TRG_CLK80  in  1  frame-word clock (80 MHz); sole clock.
- TRG_RST  in  1  reset, synchronous to TRG_CLK80, active-high.
- GEM_DATA  in  NLINKS*DW  payloads; link n = [n*DW +: DW].
- GEM_OVERFLOW  in  NLINKS  per-link >8-cluster flag.
- BXN_COUNTER  in  12  TTC bunch counter.
- BC0  in  1  bunch-crossing-zero flag.
- ENA_TEST_PAT  in  1  1 = transmit PRBS instead of GEM_DATA.
- PRBS_RST  in  1  PRBS generator reset request.
- INJ_ERR  in  1  rising edge injects one bit error.
- TRG_TX_DATA  out  NLINKS*32  TXDATA per link.
- TRG_TX_ISK  out  NLINKS*4  TXCHARISK per link.
- FRAME_START  out  1  high on the cycle the first word of a frame is presented.
- TX_SYNC_DONE  out  1  high in RUN state.
- LTNCY_TRIG  out  1  one-cycle latency-measurement strobe.

Behaviour:
- All outputs are registered; data sampled at cycle t appears at cycle t+1.
- Reset outputs:
  - TRG_TX_DATA = 32'h50BC50BC per link; TRG_TX_ISK = 4'b0101.
  - FRAME_START, TX_SYNC_DONE, LTNCY_TRIG = 0.
  - Word counter wcnt = 0, separator counter = 0, PRBS = seed.
- State machine:
  - RESET: held while TRG_RST; emits comma word.
  - RESET -> SYNC on TRG_RST low.
  - SYNC: emits comma word for SYNC_FRAMES full frames, counted by wcnt wraps.
  - SYNC -> RUN; TX_SYNC_DONE = 1 in RUN.
  - TRG_RST asserted in any state -> RESET next cycle; a partial frame is abandoned.
- Word counter wcnt:
  - Counts 0..FRAME_WORDS-1 and wraps; runs in SYNC and RUN.
  - FRAME_START is registered from (wcnt==0).
- Payload capture: at wcnt==0, per link, hold <= ENA_TEST_PAT ? prbs[DW-1:0] : GEM_DATA link slice.
- RUN word output:
  - Word 0 uses live input data, equal to hold; so frame k carries the payload sampled at its word 0.
  - Word k < FRAME_WORDS-1: data = hold[DW-1-32k -: 32], ISK = 4'b0000.
  - Last word: data = {hold[23:0], sep}, ISK = 4'b0001.
- Separator sep, per link, evaluated at last word:
  - GEM_OVERFLOW[n] -> 8'hFC.
  - Else FRAME_CTRL_TTC=0: 2-bit frame counter, incremented at each frame wrap, maps 0..3 -> BC, F7, FB, FD.
  - Else FRAME_CTRL_TTC=1: BXN_COUNTER[1:0] uses the same mapping.
  - Frame counter clears in RESET; counts in SYNC and RUN.
- PRBS:
  - One generator shared by all links; x^31+x^28+1, Fibonacci, seed 31'h7FFFFFFF.
  - Advances DW bits per frame at wcnt==0; prbs[DW-1] is the oldest bit.
  - Held at seed while TRG_RST or PRBS_RST.
  - Held at seed for 8 further frames after both deassert.
  - An 8-stage shift register, clocked at wcnt==0, extends the reset.
- INJ_ERR:
  - Rising edge, detected with a registered copy, arms a flag.
  - The next captured frame inverts hold bit 0 on link 0 only; then the flag clears.
  - A new edge while armed is absorbed.
- LTNCY_TRIG:
  - Free-running LTNCY_BITS counter, cleared in RESET.
  - Pulses (registered) when counter==0 and state != RESET.
  - Period = 2^LTNCY_BITS cycles.

Optional Feature:
- GEM_TRIG_LINK_BC0_MARKER_EN defined: BC0 sampled at wcnt==0 sets a frame flag.
  - That frame's separator on all links = 8'h5C (K28.2).
  - Priority BC0 > overflow > sequence.
  - The local frame counter is forced to 0 after that frame, so the next frame is BC.
- Undefined: BC0 is ignored; the port remains and is unused.

Test Plan:
- Reset, then release; NLINKS=2, FRAME_WORDS=2, SYNC_FRAMES=4:
  - 8 cycles of 50BC50BC/0101; TX_SYNC_DONE rises on cycle 9.
  - Then data frames begin with FRAME_START=1.
- RUN, GEM_DATA link0 = 56'h0123456789ABCD, no overflow:
  - Words 32'h01234567/0000, then 32'h89ABCDBC/0001.
  - Next frames' separators are F7, FB, FD, BC.
- GEM_OVERFLOW[1]=1 for one frame: link1 separator = FC; link0 unaffected; sequence continues.
- FRAME_CTRL_TTC=1, BXN_COUNTER=12'h002: separator FB.
- BC0 with marker enabled: separator 5C on both links; following frame BC.
- ENA_TEST_PAT=1, PRBS_RST pulse:
  - Payload equals seed-derived first DW bits for 9 frames, then advances per PRBS-31.
  - INJ_ERR edge flips exactly bit 0 of one link0 frame.
  - Bench reference-model checker counts 1 error.
- TRG_RST asserted mid-frame (wcnt=1): comma on next cycle; full SYNC sequence repeats.
